// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: next-PC controls, instruction memory port and IF/ID outputs.
// master drives controls and memory data; slave is the fetch stage itself.
interface fetch_stage_if;
  logic        stall;
  logic        flush;
  logic [1:0]  PCSrc;
  logic [31:0] branch_target;
  logic [31:0] jalr_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4_out;
  logic        valid_out;
  logic        misalign;

  modport master (
    output stall, flush, PCSrc, branch_target, jalr_target, imem_rdata,
    input  imem_addr, instr_out, pc_out, pc_plus4_out, valid_out, misalign
  );

  modport slave (
    input  stall, flush, PCSrc, branch_target, jalr_target, imem_rdata,
    output imem_addr, instr_out, pc_out, pc_plus4_out, valid_out, misalign
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC select and IF/ID register.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirects set a sticky flag and halt fetch.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic          clk,
  input logic          rst,
  fetch_stage_if.slave bus
);
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4, next_pc, pc_target;
  logic        redirect, pc_load, halted;

  assign pc_plus4 = pc_q + 32'd4;
  assign redirect = (bus.PCSrc == 2'b01) || (bus.PCSrc == 2'b10);

  always_comb begin
    unique case (bus.PCSrc)
      2'b01:   next_pc = bus.branch_target;
      2'b10:   next_pc = {bus.jalr_target[31:1], 1'b0};
      default: next_pc = pc_plus4;
    endcase
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic {RUN, HALT} run_state_e;
  run_state_e state_q, state_d;
  logic       misalign_q, misalign_d;
  logic       load_en, trap;

  assign load_en = (!bus.stall || bus.flush) && (state_q == RUN);
  assign trap    = load_en && redirect && (next_pc[1:0] != 2'b00);

  always_comb begin
    state_d    = state_q;
    misalign_d = misalign_q;
    if (trap) begin
      state_d    = HALT;
      misalign_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      misalign_q <= misalign_d;
    end
  end

  // The trapping cycle itself already squashes IF/ID, not just the cycles after it.
  assign halted       = (state_q == HALT) || trap;
  assign pc_load      = load_en && !trap;
  assign pc_target    = next_pc;
  assign bus.misalign = misalign_q;
`else
  assign halted       = 1'b0;
  assign pc_load      = !bus.stall || bus.flush;
  assign pc_target    = redirect ? {next_pc[31:2], 2'b00} : next_pc;
  assign bus.misalign = 1'b0;
`endif

  always_comb begin
    pc_d       = pc_load ? pc_target : pc_q;
    instr_d    = instr_q;
    pc_out_d   = pc_out_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (halted || bus.flush) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (!bus.stall) begin
      instr_d    = bus.imem_rdata;
      pc_out_d   = pc_q;
      pc_plus4_d = pc_plus4;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc_out_q   <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_out_q   <= pc_out_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.imem_addr    = pc_q;
  assign bus.instr_out    = instr_q;
  assign bus.pc_out       = pc_out_q;
  assign bus.pc_plus4_out = pc_plus4_q;
  assign bus.valid_out    = valid_q;
endmodule
